// File: rtl/fwd_hazard_if.sv
// EX-stage hazard bus: instruction info toward the hazard unit, bypass selects and stall back.
// master = pipeline/EX side, slave = fwd_hazard_unit.
interface fwd_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                          ex_valid;
  logic [REG_ADDR_W-1:0]         ex_rd;
  logic                          ex_regwrite;
  logic                          ex_is_load;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src;
  logic [NUM_SRC-1:0]            ex_src_used;
  logic                          flush_ex;
  logic                          stall_in;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall_out;

  modport master (
    output ex_valid, ex_rd, ex_regwrite, ex_is_load, ex_src, ex_src_used, flush_ex, stall_in,
    input  fwd_sel, stall_out
  );
  modport slave (
    input  ex_valid, ex_rd, ex_regwrite, ex_is_load, ex_src, ex_src_used, flush_ex, stall_in,
    output fwd_sel, stall_out
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit with its own DEPTH-stage destination-tag pipeline.
// Optional FWD_HAZARD_STATS_EN adds stall/forward statistics counters.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  fwd_hazard_if.slave   bus
`ifdef FWD_HAZARD_STATS_EN
  ,
  input  logic          clr_stats,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   fwd_count
`endif
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      v_q, we_q, ld_q;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];

  logic                     s0_v_d, s0_we_d, s0_ld_d;
  logic [REG_ADDR_W-1:0]    s0_rd_d;
  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic                     stall_raw;
  logic                     bubble;

  // Descending scan so the lowest-index (youngest) match overwrites older ones.
  always_comb begin
    logic [REG_ADDR_W-1:0] src;
    logic                  win_ld;
    sel_raw   = '0;
    stall_raw = 1'b0;
    src       = '0;
    win_ld    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src    = bus.ex_src[i*REG_ADDR_W +: REG_ADDR_W];
      win_ld = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (bus.ex_valid && bus.ex_src_used[i] && v_q[k] && we_q[k] &&
            (rd_q[k] == src) && (src != '0)) begin
          sel_raw[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          win_ld = ld_q[k] && (k < LOAD_LAT);
        end
      end
      stall_raw = stall_raw | win_ld;
    end
  end

  assign bubble        = stall_raw | bus.flush_ex;
  assign bus.stall_out = stall_raw & ~bus.flush_ex;
  assign bus.fwd_sel   = bubble ? '0 : sel_raw;

  assign s0_v_d  = ~bubble & bus.ex_valid & bus.ex_regwrite;
  assign s0_rd_d = bus.ex_rd;
  assign s0_we_d = bus.ex_regwrite;
  assign s0_ld_d = bus.ex_is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      we_q <= '0;
      ld_q <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else if (!bus.stall_in) begin
      v_q  <= {v_q[DEPTH-2:0],  s0_v_d};
      we_q <= {we_q[DEPTH-2:0], s0_we_d};
      ld_q <= {ld_q[DEPTH-2:0], s0_ld_d};
      rd_q[0] <= s0_rd_d;
      for (int k = 1; k < DEPTH; k++) rd_q[k] <= rd_q[k-1];
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (bus.stall_out && !bus.stall_in && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if ((|bus.fwd_sel) && !bus.stall_in && (fwd_cnt_q != 32'hFFFF_FFFF))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (clr_stats) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign fwd_count    = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two instances (DEPTH=3/LOAD_LAT=1 and DEPTH=4/LOAD_LAT=2) driven in lockstep.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_strobe = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_if #(.REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(3)) ifa ();
  fwd_hazard_if #(.REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(4)) ifb ();

`ifdef FWD_HAZARD_STATS_EN
  logic        clr_stats = 1'b0;
  logic [31:0] stall_cycles_a, fwd_count_a, stall_cycles_b, fwd_count_b;
`endif

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .LOAD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
`ifdef FWD_HAZARD_STATS_EN
    , .clr_stats(clr_stats), .stall_cycles(stall_cycles_a), .fwd_count(fwd_count_a)
`endif
  );
  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(4), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
`ifdef FWD_HAZARD_STATS_EN
    , .clr_stats(clr_stats), .stall_cycles(stall_cycles_b), .fwd_count(fwd_count_b)
`endif
  );

  typedef struct {
    int          dut;
    int          kind;   // 0 = bypass/stall outputs, 1 = stall_cycles counter
    string       name;
    logic [2:0]  sel0;
    logic [2:0]  sel1;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic expect_out(input int dut, input string name, input logic [2:0] s0,
                            input logic [2:0] s1, input logic st);
    exp_t e;
    e.dut = dut; e.kind = 0; e.name = name; e.sel0 = s0; e.sel1 = s1; e.stall = st; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  task automatic expect_cnt(input int dut, input string name, input logic [31:0] c);
    exp_t e;
    e.dut = dut; e.kind = 1; e.name = name; e.sel0 = '0; e.sel1 = '0; e.stall = 1'b0; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic fire();
    #1 chk_strobe = 1'b1;
    #1 chk_strobe = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic fl, input logic si);
    ifa.ex_valid = v;  ifa.ex_rd = rd; ifa.ex_regwrite = we; ifa.ex_is_load = ld;
    ifa.ex_src = {s1, s0}; ifa.ex_src_used = used; ifa.flush_ex = fl; ifa.stall_in = si;
    ifb.ex_valid = v;  ifb.ex_rd = rd; ifb.ex_regwrite = we; ifb.ex_is_load = ld;
    ifb.ex_src = {s1, s0}; ifb.ex_src_used = used; ifb.flush_ex = fl; ifb.stall_in = si;
  endtask

  task automatic vec(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                     input logic fl, input logic si);
    @(posedge clk);
    #1 drive(v, rd, we, ld, s0, s1, used, fl, si);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // Monitor: drains every pending expectation whenever the stimulus marks outputs as settled.
  initial begin
    forever begin
      @(posedge chk_strobe);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [2:0]  a0, a1;
        logic        ast;
        logic [31:0] acnt;
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          a0 = {1'b0, ifa.fwd_sel[1:0]}; a1 = {1'b0, ifa.fwd_sel[3:2]}; ast = ifa.stall_out;
        end else begin
          a0 = ifb.fwd_sel[2:0]; a1 = ifb.fwd_sel[5:3]; ast = ifb.stall_out;
        end
        acnt = '0;
`ifdef FWD_HAZARD_STATS_EN
        acnt = (e.dut == 0) ? stall_cycles_a : stall_cycles_b;
`endif
        checks++;
        if (e.kind == 0) begin
          if (a0 !== e.sel0 || a1 !== e.sel1 || ast !== e.stall) begin
            failures++;
            $display("FAIL %s dut%0d: got sel0=%0d sel1=%0d stall=%0b, want sel0=%0d sel1=%0d stall=%0b",
                     e.name, e.dut, a0, a1, ast, e.sel0, e.sel1, e.stall);
          end
        end else begin
          if (acnt !== e.cnt) begin
            failures++;
            $display("FAIL %s dut%0d: got stall_cycles=%0d, want %0d", e.name, e.dut, acnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    #2;
    expect_out(0, "reset", 0, 0, 0);
    expect_out(1, "reset", 0, 0, 0);
    fire();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back ALU
    vec(1, 5, 1, 0, 0, 0, 2'b00, 0, 0);  expect_out(0, "alu_prod", 0, 0, 0); fire();
    vec(1, 0, 0, 0, 5, 7, 2'b11, 0, 0);  expect_out(0, "b2b_fwd", 1, 0, 0);
    expect_out(1, "b2b_fwd", 1, 0, 0); fire();
    // Youngest wins
    vec(1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
    vec(1, 3, 1, 0, 3, 0, 2'b01, 0, 0);  expect_out(0, "young_s0", 1, 0, 0); fire();
    vec(1, 0, 0, 0, 3, 0, 2'b01, 0, 0);  expect_out(0, "young_both", 1, 0, 0); fire();
    vec(1, 0, 0, 0, 3, 0, 2'b01, 0, 0);  expect_out(0, "young_s1", 2, 0, 0); fire();
    // r0 and unused operands
    vec(1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    vec(1, 9, 1, 0, 0, 0, 2'b11, 0, 0);  expect_out(0, "r0_nomatch", 0, 0, 0); fire();
    vec(1, 0, 0, 0, 9, 9, 2'b01, 0, 0);  expect_out(0, "unused_src1", 1, 0, 0); fire();

    // Load-use: A stalls 1 cycle, B stalls 2
    do_reset();
    vec(1, 8, 1, 1, 0, 0, 2'b00, 0, 0);  expect_out(0, "ld_prod", 0, 0, 0); fire();
    vec(1, 10, 1, 0, 8, 0, 2'b01, 0, 0); expect_out(0, "ld_stall1", 0, 0, 1);
    expect_out(1, "ld_stall1", 0, 0, 1); fire();
    vec(1, 10, 1, 0, 8, 0, 2'b01, 0, 0); expect_out(0, "ld_fwd_l1", 2, 0, 0);
    expect_out(1, "ld_stall2", 0, 0, 1); fire();
    vec(1, 10, 1, 0, 8, 0, 2'b01, 0, 0); expect_out(0, "ld_after", 3, 0, 0);
    expect_out(1, "ld_fwd_l2", 3, 0, 0); fire();

    // Freeze and flush
    do_reset();
    vec(1, 6, 1, 0, 0, 0, 2'b00, 0, 0);
    for (int c = 0; c < 3; c++) begin
      vec(1, 11, 1, 0, 6, 0, 2'b01, 0, 1);
      expect_out(0, "freeze", 1, 0, 0); expect_out(1, "freeze", 1, 0, 0); fire();
    end
    vec(1, 0, 0, 0, 6, 0, 2'b01, 0, 0);  expect_out(0, "post_freeze", 1, 0, 0); fire();
    vec(1, 12, 1, 0, 6, 0, 2'b01, 1, 0); expect_out(0, "flush_out", 0, 0, 0);
    expect_out(1, "flush_out", 0, 0, 0); fire();
    vec(1, 0, 0, 0, 6, 12, 2'b11, 0, 0); expect_out(0, "flush_bubble", 3, 0, 0);
    expect_out(1, "flush_bubble", 3, 0, 0); fire();
    // Flush overrides a load-use stall
    do_reset();
    vec(1, 4, 1, 1, 0, 0, 2'b00, 0, 0);
    vec(1, 0, 0, 0, 4, 4, 2'b11, 1, 0);  expect_out(0, "flush_ld", 0, 0, 0);
    expect_out(1, "flush_ld", 0, 0, 0); fire();

    // Async reset while stalled
    do_reset();
    vec(1, 8, 1, 1, 0, 0, 2'b00, 0, 0);
    vec(1, 0, 0, 0, 8, 0, 2'b01, 0, 0);  expect_out(0, "pre_rst_stall", 0, 0, 1);
    expect_out(1, "pre_rst_stall", 0, 0, 1); fire();
    #1 rst_n = 1'b0;
    expect_out(0, "rst_mid_stall", 0, 0, 0); expect_out(1, "rst_mid_stall", 0, 0, 0); fire();
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef FWD_HAZARD_STATS_EN
    expect_cnt(1, "stats_after_rst", 0); fire();
`endif
    vec(1, 8, 1, 1, 0, 0, 2'b00, 0, 0);
    vec(1, 0, 0, 0, 8, 0, 2'b01, 0, 0);  expect_out(1, "rst_ld_stall1", 0, 0, 1); fire();
    vec(1, 0, 0, 0, 8, 0, 2'b01, 0, 0);  expect_out(1, "rst_ld_stall2", 0, 0, 1); fire();
    vec(1, 0, 0, 0, 8, 0, 2'b01, 0, 0);  expect_out(1, "rst_ld_fwd", 3, 0, 0);
`ifdef FWD_HAZARD_STATS_EN
    expect_cnt(1, "stats_two_stalls", 2);
`endif
    fire();

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
